// File: rtl/conv_result_writer.sv
// Converts signed accumulator sums to clamped 8-bit pixels, packs four per word
// (little-endian) and writes the words to sequential memory addresses, one frame per start.
module conv_result_writer #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       pix_count,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_valid,
  output logic              acc_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       remain_reg;
  logic [1:0]        lane_reg;
  logic [31:0]       word_reg;
  logic              acc_ready_reg;
  logic              mem_we_reg;
  logic              busy_reg;
  logic              done_reg;

  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              pix_byte;
  logic [31:0]             word_next;
  logic                    accept;
  logic                    word_full;
  logic                    last_pixel;

  assign shifted = $signed(acc_in) >>> SHIFT;

  // Negative values floor at 0; anything with bits above bit 7 saturates at 255.
  always_comb begin
    pix_byte = shifted[7:0];
    if (shifted[ACC_W-1])
      pix_byte = 8'h00;
    else if (|shifted[ACC_W-2:8])
      pix_byte = 8'hFF;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (lane_reg == 2'(gi)) ? pix_byte : word_reg[8*gi +: 8];
    end
  endgenerate

  assign accept     = (state_reg == COLLECT) && acc_valid && acc_ready_reg;
  assign word_full  = (lane_reg == 2'd3);
  assign last_pixel = (remain_reg == 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remain_reg    <= '0;
      lane_reg      <= '0;
      word_reg      <= '0;
      acc_ready_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg <= 1'b1;
            if (pix_count != 16'd0) begin
              addr_reg      <= base_addr;
              remain_reg    <= pix_count;
              lane_reg      <= '0;
              word_reg      <= '0;
              acc_ready_reg <= 1'b1;
              state_reg     <= COLLECT;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            word_reg   <= word_next;
            remain_reg <= remain_reg - 16'd1;
            if (word_full || last_pixel) begin
              acc_ready_reg <= 1'b0;
              mem_we_reg    <= 1'b1;
              state_reg     <= WRITE;
            end else begin
              lane_reg <= lane_reg + 2'd1;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we_reg <= 1'b0;
            addr_reg   <= addr_reg + ADDR_ONE;
            word_reg   <= '0;
            lane_reg   <= '0;
            if (remain_reg == 16'd0) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              acc_ready_reg <= 1'b1;
              state_reg     <= COLLECT;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign acc_ready = acc_ready_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = word_reg;
  assign mem_we    = mem_we_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: hand-computed packed words, handshake
// timing, zero-length frames, mid-frame reset and address wrap.
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] pix_count;
  logic [31:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;

  conv_result_writer #(.ACC_W(32), .ADDR_W(16), .SHIFT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .pix_count(pix_count), .acc_in(acc_in), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ack(mem_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cycles = 0;
  int accepts = 0;
  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] feed_q[$];

  // Observe the bus mid-cycle; a write is committed on the edge after we&&ack is seen.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) we_cycles++;
      if (mem_we && mem_ack) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
      if (acc_valid && acc_ready) accepts++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    we_cycles = 0;
    accepts = 0;
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; pix_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed();
    int t;
    while (feed_q.size() > 0) begin
      acc_in = feed_q.pop_front();
      acc_valid = 1'b1;
      t = 0;
      while (!acc_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t == 100) begin
        chk("feed_timeout", 1, 0);
        feed_q.delete();
      end else begin
        @(posedge clk); #1;
      end
    end
    acc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, done, 1);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [15:0] a, input logic [31:0] d);
    if (wr_addr_q.size() > idx) begin
      chk({tag, "_addr"}, wr_addr_q[idx], a);
      chk({tag, "_data"}, wr_data_q[idx], d);
    end else begin
      chk({tag, "_missing"}, wr_addr_q.size(), idx + 1);
    end
  endtask

  initial begin
    logic [15:0] held_addr;
    logic [31:0] held_data;
    int t;
    reset = 1'b1; start = 1'b0; base_addr = '0; pix_count = '0;
    acc_in = '0; acc_valid = 1'b0; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", acc_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Frame 1: clamp below 0, above 255, and in range; single word.
    clear_log();
    pulse_start(16'h0100, 16'd4);
    chk("f1_busy_rise", busy, 1);
    chk("f1_ready_rise", acc_ready, 1);
    feed_q = '{32'h0000_1234, 32'h0000_AB00, 32'hFFFF_F000, 32'h0001_2300};
    feed();
    chk("f1_we_rise", mem_we, 1);
    chk("f1_ready_low", acc_ready, 0);
    wait_done("f1_done");
    chk("f1_busy_at_done", busy, 1);
    @(negedge clk);
    chk("f1_busy_fall", busy, 0);
    chk("f1_done_fall", done, 0);
    chk("f1_nwr", wr_addr_q.size(), 1);
    chk_write("f1_w0", 0, 16'h0100, 32'hFF00_AB12);

    // Frame 2: six pixels -> one full and one partial word.
    clear_log();
    pulse_start(16'h0200, 16'd6);
    feed_q = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    feed();
    wait_done("f2_done");
    chk("f2_nwr", wr_addr_q.size(), 2);
    chk("f2_we_cycles", we_cycles, 2);
    chk_write("f2_w0", 0, 16'h0200, 32'h0403_0201);
    chk_write("f2_w1", 1, 16'h0201, 32'h0000_0605);

    // Frame 3: ack held off three cycles; stray valid during the wait.
    clear_log();
    mem_ack = 1'b0;
    pulse_start(16'h0100, 16'd4);
    feed_q = '{32'h0000_1234, 32'h0000_AB00, 32'hFFFF_F000, 32'h0001_2300};
    feed();
    t = 0;
    @(negedge clk);
    while (!mem_we && t < 50) begin @(negedge clk); t++; end
    chk("f3_we_c1", mem_we, 1);
    held_addr = mem_addr;
    held_data = mem_wdata;
    chk("f3_addr_c1", held_addr, 16'h0100);
    chk("f3_data_c1", held_data, 32'hFF00_AB12);
    @(posedge clk); #1; acc_valid = 1'b1; acc_in = 32'h0000_7F00;
    @(negedge clk);
    chk("f3_we_c2", mem_we, 1);
    chk("f3_ready_c2", acc_ready, 0);
    @(posedge clk); #1; acc_valid = 1'b0;
    @(negedge clk);
    chk("f3_addr_c3", mem_addr, held_addr);
    chk("f3_ready_c3", acc_ready, 0);
    @(posedge clk); #1; mem_ack = 1'b1;
    @(negedge clk);
    chk("f3_we_c4", mem_we, 1);
    chk("f3_data_c4", mem_wdata, held_data);
    wait_done("f3_done");
    chk("f3_we_cycles", we_cycles, 4);
    chk("f3_accepts", accepts, 4);
    chk("f3_nwr", wr_addr_q.size(), 1);

    // Frame 4: zero-length frame, then a frame with a stray start while busy.
    clear_log();
    pulse_start(16'h0123, 16'd0);
    chk("f4_done_next", done, 1);
    chk("f4_busy_zero", busy, 1);
    @(posedge clk); #1;
    chk("f4_done_fall", done, 0);
    chk("f4_nwe", we_cycles, 0);
    pulse_start(16'h0400, 16'd4);
    pulse_start(16'h0500, 16'd1);
    feed_q = '{32'h100, 32'h200, 32'h300, 32'h400};
    feed();
    wait_done("f4b_done");
    chk("f4b_nwr", wr_addr_q.size(), 1);
    chk_write("f4b_w0", 0, 16'h0400, 32'h0403_0201);

    // Frame 5: reset after two pixels, then a clean frame.
    clear_log();
    pulse_start(16'h0600, 16'd4);
    feed_q = '{32'h0000_0900, 32'h0000_0800};
    feed();
    reset = 1'b1;
    #1;
    chk("f5_rst_ready", acc_ready, 0);
    chk("f5_rst_busy", busy, 0);
    chk("f5_rst_addr", mem_addr, 0);
    chk("f5_rst_wdata", mem_wdata, 0);
    chk("f5_rst_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("f5_no_write", wr_addr_q.size(), 0);
    pulse_start(16'h0300, 16'd4);
    feed_q = '{32'h0A00, 32'h0B00, 32'h0C00, 32'h0D00};
    feed();
    wait_done("f5b_done");
    chk("f5b_nwr", wr_addr_q.size(), 1);
    chk_write("f5b_w0", 0, 16'h0300, 32'h0D0C_0B0A);

    // Frame 6: address wraps from 0xFFFF to 0x0000.
    clear_log();
    pulse_start(16'hFFFF, 16'd8);
    feed_q = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600, 32'h700, 32'h800};
    feed();
    wait_done("f6_done");
    chk("f6_nwr", wr_addr_q.size(), 2);
    chk_write("f6_w0", 0, 16'hFFFF, 32'h0403_0201);
    chk_write("f6_w1", 1, 16'h0000, 32'h0807_0605);

    // Frame 7: clamp edges (0xFF exact, 0x100, 0x00, most negative).
    clear_log();
    pulse_start(16'h0010, 16'd4);
    feed_q = '{32'h0000_FFFF, 32'h0001_0000, 32'h0000_00FF, 32'h8000_0000};
    feed();
    wait_done("f7_done");
    chk_write("f7_w0", 0, 16'h0010, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Drains signed 32-bit convolution sums from the accumulator and writes them to output data memory as packed 8-bit pixels. Each sum is arithmetically right-shifted by `SHIFT`, clamped to 0..255, and packed four pixels per 32-bit word, little-endian. Words are written to sequential addresses from a programmable base. The block sits between the accumulator output and the output-image memory port, and runs one frame per `start` pulse.

## Interface
Parameters:
- `ACC_W`, 32, accumulator sum width (signed)
- `ADDR_W`, 16, memory word-address width
- `SHIFT`, 8, arithmetic right shift applied to each sum before clamping

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; begins a frame; ignored unless idle
- `base_addr`  in  ADDR_W  first word address; sampled on accepted `start`
- `pix_count`  in  16  pixels in frame; sampled on accepted `start`
- `acc_in`  in  ACC_W  signed sum from accumulator
- `acc_valid`  in  1  `acc_in` valid
- `acc_ready`  out  1  block accepts `acc_in` this cycle
- `mem_addr`  out  ADDR_W  write word address
- `mem_wdata`  out  32  packed pixel word
- `mem_we`  out  1  write request; held until acknowledged
- `mem_ack`  in  1  memory accepted the write (may be same cycle as `mem_we`)
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - `start` with `pix_count != 0` latches base and count, then goes to COLLECT.
  - `start` with `pix_count == 0` goes to DONE.
- COLLECT:
  - `acc_ready = 1`. A pixel is accepted when `acc_valid && acc_ready` at the clock edge.
  - Pixel value: `p = acc_in >>> SHIFT` (signed). Output 0 if `p < 0`, 255 if `p > 255`, else `p[7:0]`.
  - Pixel k of the current word (k = 0..3) goes to bits `[8k+7:8k]`.
  - Goes to WRITE after the 4th pixel of the word, or after the last pixel of the frame.
  - In a partial final word, unfilled bytes are 0.
- WRITE:
  - `acc_ready = 0`, `mem_we = 1`; `mem_addr` and `mem_wdata` are stable.
  - On `mem_ack`: address increments by 1 and the byte buffer clears.
  - Then goes to DONE if no pixels remain, else back to COLLECT.
- DONE: `done = 1` for one cycle, then IDLE.
- `busy = 1` in COLLECT, WRITE and DONE.
- `start` outside IDLE is ignored.
- Address wraps modulo 2^ADDR_W.
- Reset mid-frame: all outputs go immediately to their reset values. The partial word is discarded and not written, and the FSM returns to IDLE.

## Timing
- Reset values: `acc_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0.
- `busy` and `acc_ready` rise the cycle after an accepted `start`.
- `mem_we` rises the cycle after the edge that accepts the word's final pixel.
- With `mem_ack` tied high, a write lasts 1 cycle. Peak throughput is 4 pixels per 5 cycles.
- `mem_ack` is sampled only while `mem_we = 1`; ack outside WRITE is ignored.
- `done` asserts the cycle after the final acknowledged write, or the cycle after `start` when `pix_count == 0`.
- `busy` falls together with `done`.
- `acc_valid` while `acc_ready = 0` is not consumed; the upstream holds data.

## Test plan
- base 0x0100, count 4; sums 0x00001234, 0x0000AB00, 0xFFFFF000, 0x00012300, `mem_ack` tied high -> single write at addr 0x0100, data 0xFF00AB12, then `done` pulse, `busy` low.
- base 0x0200, count 6; sums 0x100, 0x200, ..., 0x600 -> writes: 0x0200 = 0x04030201, 0x0201 = 0x00000605. Exactly two `mem_we` cycles.
- Same frame as the first scenario, with `mem_ack` delayed 3 cycles -> `mem_we`, addr and data stable for 4 cycles, `acc_ready` low throughout. A `acc_valid` pulse during the wait is not consumed.
- `start` with count 0 -> `done` pulses the next cycle, no `mem_we`. A second `start` pulsed while busy in another frame -> no effect on addr or count.
- Reset asserted after 2 of 4 pixels accepted -> all outputs 0 immediately, no write issued. A following frame with base 0x0300 writes only its own data at 0x0300.
- base 0xFFFF, count 8 -> writes at 0xFFFF then 0x0000.
